// File: rtl/rgb_pwm_decoder_if.sv
// rgb_pwm_decoder_if: PWM input lines plus the recovered-code outputs of
// rgb_pwm_decoder.
//   RGB       - PWM inputs, RGB[0]=R, RGB[1]=G, RGB[2]=B (source -> decoder)
//   SW        - recovered 6-bit code, 2 bits per colour (decoder -> sink)
//   win_valid - one-cycle pulse per completed measurement window
//   locked    - SW agrees with the two most recent windows
// master: the side that drives the PWM lines and observes the code.
// slave : the decoder itself.
interface rgb_pwm_decoder_if;
  logic [2:0] RGB;
  logic [5:0] SW;
  logic       win_valid;
  logic       locked;

  modport master (output RGB, input SW, win_valid, locked);
  modport slave  (input RGB, output SW, win_valid, locked);
endinterface

// File: rtl/rgb_pwm_decoder.sv
// rgb_pwm_decoder: recovers the 2-bit-per-colour duty code from three PWM
// lines. High time is measured per channel over fixed windows of PERIOD
// clocks, quantised to 4 levels, and published once two consecutive
// windows agree.
//   clock - system clock
//   reset - synchronous, active-high
//   bus   - rgb_pwm_decoder_if.slave (RGB in; SW, win_valid, locked out)
// All outputs are registered; there is no combinational path from RGB.

// Per-channel high-time counter and quantiser.
//   pwm     - one PWM line
//   end_win - window counter is at PERIOD-1 this cycle
//   code    - quantised duty of the window that ends this cycle (only
//             meaningful while end_win is high)
module rgb_pwm_chan #(
  parameter int PERIOD = 3125,
  parameter int CW     = $clog2(PERIOD+1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pwm,
  input  logic       end_win,
  output logic [1:0] code
);
  localparam logic [CW-1:0] T1 = CW'(PERIOD/8);
  localparam logic [CW-1:0] T2 = CW'((3*PERIOD)/8);
  localparam logic [CW-1:0] T3 = CW'((5*PERIOD)/8);

  logic [CW-1:0] hi;
  logic [CW-1:0] h;

  // h includes the current sample so the last cycle of a window counts;
  // CW holds PERIOD itself, so a 100% window cannot overflow.
  assign h = hi + CW'(pwm);

  always_comb begin
    if      (h < T1) code = 2'd0;
    else if (h < T2) code = 2'd1;
    else if (h < T3) code = 2'd2;
    else             code = 2'd3;
  end

  always_ff @(posedge clock) begin
    if (reset)        hi <= '0;
    else if (end_win) hi <= '0;
    else              hi <= h;
  end
endmodule

module rgb_pwm_decoder #(
  parameter int PERIOD = 3125,
  localparam int CW    = $clog2(PERIOD+1)
) (
  input logic         clock,
  input logic         reset,
  rgb_pwm_decoder_if.slave bus
);
  localparam int NUM_LANES = 3;

  localparam logic [1:0] ACQ     = 2'd0;
  localparam logic [1:0] CONFIRM = 2'd1;
  localparam logic [1:0] LOCK    = 2'd2;

  logic [CW-1:0]                cnt;
  logic                         end_win;
  logic [NUM_LANES-1:0][1:0]    code;
  logic [5:0]                   new_code;
  logic [5:0]                   cand;
  logic [1:0]                   state;

  assign end_win  = (cnt == CW'(PERIOD-1));
  assign new_code = code;   // lane 0 (R) lands in [1:0]

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      rgb_pwm_chan #(.PERIOD(PERIOD), .CW(CW)) u_chan (
        .clock   (clock),
        .reset   (reset),
        .pwm     (bus.RGB[g]),
        .end_win (end_win),
        .code    (code[g])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt           <= '0;
      state         <= ACQ;
      cand          <= '0;
      bus.SW        <= '0;
      bus.locked    <= 1'b0;
      bus.win_valid <= 1'b0;
    end else begin
      bus.win_valid <= end_win;
      cnt           <= end_win ? '0 : cnt + CW'(1);
      if (end_win) begin
        case (state)
          ACQ: begin
            cand  <= new_code;
            state <= CONFIRM;
          end
          CONFIRM: begin
            if (new_code == cand) begin
              bus.SW     <= new_code;
              bus.locked <= 1'b1;
              state      <= LOCK;
            end else begin
              cand <= new_code;
            end
          end
          LOCK: begin
            // A single disagreeing window drops lock but keeps the last
            // good code on SW until a new value is confirmed.
            if (new_code != bus.SW) begin
              cand       <= new_code;
              bus.locked <= 1'b0;
              state      <= CONFIRM;
            end
          end
          default: state <= ACQ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rgb_pwm_decoder.sv
module tb_rgb_pwm_decoder;
  localparam int PERIOD = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rgb_pwm_decoder_if bus ();
  rgb_pwm_decoder #(.PERIOD(PERIOD)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int n_push = 0;
  int n_pop = 0;

  // expected {locked, SW} per completed window
  logic [6:0] sb [$];

  // reference: publish when two consecutive windows read the same code
  logic [5:0] m_prev;
  logic       m_have_prev;
  logic [5:0] m_sw;
  logic       m_locked;

  logic [2:0] pat [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // thresholds for PERIOD=16: 2, 6, 10
  function automatic logic [1:0] quant(input int h);
    if (h < 2)  return 2'd0;
    if (h < 6)  return 2'd1;
    if (h < 10) return 2'd2;
    return 2'd3;
  endfunction

  function automatic void model_reset();
    m_prev = '0; m_have_prev = 1'b0; m_sw = '0; m_locked = 1'b0;
  endfunction

  // fill pattern slots [from..15] with per-channel high time h and phase ph
  task automatic fill(input int h0, input int h1, input int h2, input int ph, input int from);
    int hh [3];
    hh[0] = h0; hh[1] = h1; hh[2] = h2;
    for (int i = from; i < 16; i++)
      for (int c = 0; c < 3; c++)
        pat[i][c] = (((i - ph + 16) % 16) < hh[c]);
  endtask

  // one full window from pat[]; starts at a negedge aligned to counter==0
  task automatic drive_win();
    int cntc [3];
    logic [5:0] nc;
    for (int c = 0; c < 3; c++) cntc[c] = 0;
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < 3; c++) cntc[c] += int'(pat[i][c]);
    nc = {quant(cntc[2]), quant(cntc[1]), quant(cntc[0])};
    if (m_have_prev && nc == m_prev) begin
      m_sw = nc; m_locked = 1'b1;
    end else if (m_have_prev) begin
      m_locked = 1'b0;
    end
    m_prev = nc; m_have_prev = 1'b1;
    sb.push_back({m_locked, m_sw});
    n_push++;
    for (int i = 0; i < 16; i++) begin
      bus.RGB = pat[i];
      @(negedge clock);
      chk("win_valid", 32'(bus.win_valid), 32'(i == 15));
    end
  endtask

  task automatic duty_wins(input int h0, input int h1, input int h2, input int ph, input int n);
    fill(h0, h1, h2, ph, 0);
    repeat (n) drive_win();
  endtask

  // scoreboard drain on every window pulse
  always @(negedge clock) begin
    if (!reset && bus.win_valid) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(1), 32'(0));
      end else begin
        logic [6:0] e;
        e = sb.pop_front();
        n_pop++;
        chk("SW", 32'(bus.SW), 32'(e[5:0]));
        chk("locked", 32'(bus.locked), 32'(e[6]));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.RGB = 3'b000;
    model_reset();
    repeat (2) begin
      @(negedge clock);
      chk("rst_SW", 32'(bus.SW), 32'(0));
      chk("rst_locked", 32'(bus.locked), 32'(0));
      chk("rst_win_valid", 32'(bus.win_valid), 32'(0));
    end
    reset = 1'b0;

    // idle lines: SW=0 locked after 2nd window
    duty_wins(0, 0, 0, 0, 2);
    // 25% on all channels, two different phases
    duty_wins(4, 4, 4, 3, 2);
    duty_wins(4, 4, 4, 11, 1);
    // R=50% G=75% B=100% -> 111110
    duty_wins(8, 12, 16, 5, 2);
    // threshold boundaries
    duty_wins(1, 1, 1, 0, 2);
    duty_wins(2, 2, 2, 7, 2);
    duty_wins(5, 6, 9, 2, 2);
    duty_wins(10, 15, 0, 9, 2);

    // locked at 010101, switch to 110110 mid-window
    duty_wins(4, 4, 4, 0, 2);
    fill(4, 4, 4, 0, 0);
    fill(8, 4, 12, 0, 8);
    drive_win();
    duty_wins(8, 4, 12, 0, 2);

    // alternating R 01/10: never confirms
    repeat (2) begin
      duty_wins(4, 0, 0, 1, 1);
      duty_wins(8, 0, 0, 1, 1);
    end

    // lock, then reset at counter==9
    duty_wins(4, 4, 4, 6, 3);
    fill(12, 12, 12, 0, 0);
    for (int i = 0; i < 9; i++) begin
      bus.RGB = pat[i];
      @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_SW", 32'(bus.SW), 32'(0));
    chk("midrst_locked", 32'(bus.locked), 32'(0));
    chk("midrst_win_valid", 32'(bus.win_valid), 32'(0));
    reset = 1'b0;
    model_reset();
    duty_wins(12, 12, 12, 0, 2);

    @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    chk("pop_count", 32'(n_pop), 32'(n_push));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
